// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline sequencer and the datapath registers.
// The master side is the sequencer; the slave side is the datapath.
interface pipeline_ctrl_if;
  logic        load_use_ID;
  logic        br_taken_EX;
  logic        mem_req_MEM;
  logic        mem_ack;
  logic [4:0]  exp_vector_MEM;
  logic        illegal_addr_MEM;
  logic        mret_MEM;
  logic [31:0] PCurrent_MEM;
  logic [31:0] mtvec;
  logic [31:0] mepc_in;

  logic        EN_IF;
  logic        EN_ID;
  logic        EN_EX;
  logic        EN_MEM;
  logic        EN_WB;
  logic        flush_ID;
  logic        flush_EX;
  logic        flush_MEM;
  logic        flush_WB;
  logic        pc_redirect;
  logic [31:0] pc_target;
  logic        trap_we;
  logic [31:0] mepc_out;
  logic [4:0]  mcause_out;

  modport master (
    input  load_use_ID, br_taken_EX, mem_req_MEM, mem_ack, exp_vector_MEM,
           illegal_addr_MEM, mret_MEM, PCurrent_MEM, mtvec, mepc_in,
    output EN_IF, EN_ID, EN_EX, EN_MEM, EN_WB,
           flush_ID, flush_EX, flush_MEM, flush_WB,
           pc_redirect, pc_target, trap_we, mepc_out, mcause_out
  );

  modport slave (
    output load_use_ID, br_taken_EX, mem_req_MEM, mem_ack, exp_vector_MEM,
           illegal_addr_MEM, mret_MEM, PCurrent_MEM, mtvec, mepc_in,
    input  EN_IF, EN_ID, EN_EX, EN_MEM, EN_WB,
           flush_ID, flush_EX, flush_MEM, flush_WB,
           pc_redirect, pc_target, trap_we, mepc_out, mcause_out
  );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: stalls, flushes, memory-wait with timeout,
// trap entry/return and the trap CSR write.
module pipeline_ctrl #(
  parameter int       MEM_TIMEOUT      = 16,
  parameter bit [4:0] ADDR_FAULT_CAUSE = 5'd5,
  parameter bit [4:0] TIMEOUT_CAUSE    = 5'd7
) (
  input logic              clk,
  input logic              rst,
  pipeline_ctrl_if.master  bus
);
  localparam int CW = ($clog2(MEM_TIMEOUT) > 2) ? $clog2(MEM_TIMEOUT) : 2;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, TRAP, RET} state_t;

  state_t      state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0] mepc_reg, mepc_next;
  logic [4:0]  mcause_reg, mcause_next;

  logic        en_if, en_id, en_ex, en_mem, en_wb;
  logic        fl_id, fl_ex, fl_mem, fl_wb;
  logic        redirect;
  logic [31:0] target;
  logic        exc;
  logic [4:0]  cause;

  assign exc   = (bus.exp_vector_MEM != 5'd0) | bus.illegal_addr_MEM;
  assign cause = bus.illegal_addr_MEM ? ADDR_FAULT_CAUSE : bus.exp_vector_MEM;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg  <= RUN;
      cnt_reg    <= '0;
      mepc_reg   <= '0;
      mcause_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      mepc_reg   <= mepc_next;
      mcause_reg <= mcause_next;
    end
  end

  always_comb begin
    en_if = 1'b1; en_id = 1'b1; en_ex = 1'b1; en_mem = 1'b1; en_wb = 1'b1;
    fl_id = 1'b0; fl_ex = 1'b0; fl_mem = 1'b0; fl_wb = 1'b0;
    redirect    = 1'b0;
    target      = '0;
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    mepc_next   = mepc_reg;
    mcause_next = mcause_reg;
    case (state_reg)
      RUN: begin
        if (exc) begin
          en_if = 1'b0;
          fl_id = 1'b1; fl_ex = 1'b1; fl_mem = 1'b1; fl_wb = 1'b1;
          mepc_next   = bus.PCurrent_MEM;
          mcause_next = cause;
          state_next  = TRAP;
        end else if (bus.mret_MEM) begin
          // mret itself continues into WB
          en_if = 1'b0;
          fl_id = 1'b1; fl_ex = 1'b1; fl_mem = 1'b1;
          state_next = RET;
        end else if (bus.mem_req_MEM && !bus.mem_ack) begin
          en_if = 1'b0; en_id = 1'b0; en_ex = 1'b0; en_mem = 1'b0;
          fl_wb      = 1'b1;
          cnt_next   = '0;
          state_next = MEM_WAIT;
        end else if (bus.br_taken_EX) begin
          // a branch squashes the load-use victim, so its stall is moot
          fl_id = 1'b1; fl_ex = 1'b1;
        end else if (bus.load_use_ID) begin
          en_if = 1'b0; en_id = 1'b0;
          fl_ex = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ack) begin
          state_next = RUN;
        end else if (cnt_reg == CNT_LAST) begin
          en_if = 1'b0;
          fl_id = 1'b1; fl_ex = 1'b1; fl_mem = 1'b1; fl_wb = 1'b1;
          mepc_next   = bus.PCurrent_MEM;
          mcause_next = TIMEOUT_CAUSE;
          state_next  = TRAP;
        end else begin
          en_if = 1'b0; en_id = 1'b0; en_ex = 1'b0; en_mem = 1'b0;
          fl_wb    = 1'b1;
          cnt_next = cnt_reg + 1'b1;
        end
      end
      TRAP: begin
        redirect = 1'b1;
        target   = bus.mtvec;
        fl_id = 1'b1; fl_ex = 1'b1; fl_mem = 1'b1; fl_wb = 1'b1;
        state_next = RUN;
      end
      RET: begin
        redirect   = 1'b1;
        target     = bus.mepc_in;
        fl_id      = 1'b1;
        state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Everything is held inactive while reset is asserted.
  assign bus.EN_IF       = rst & en_if;
  assign bus.EN_ID       = rst & en_id;
  assign bus.EN_EX       = rst & en_ex;
  assign bus.EN_MEM      = rst & en_mem;
  assign bus.EN_WB       = rst & en_wb;
  assign bus.flush_ID    = rst & fl_id;
  assign bus.flush_EX    = rst & fl_ex;
  assign bus.flush_MEM   = rst & fl_mem;
  assign bus.flush_WB    = rst & fl_wb;
  assign bus.pc_redirect = rst & redirect;
  assign bus.pc_target   = (rst && redirect) ? target : 32'd0;
  assign bus.trap_we     = rst & (state_reg == TRAP);
  assign bus.mepc_out    = mepc_reg;
  assign bus.mcause_out  = mcause_reg;
endmodule
